ascon_round_sched: RTL and testbench
====================================

ASCON_ROUND_SCHED -- requirements
Module: ascon_round_sched

Interface
REQ-001 Parameter PA_ROUNDS, default 12, rounds of p^a for initialization and finalization.
REQ-002 Parameter PB_ROUNDS, default 6, rounds of p^b after each intermediate data block.
REQ-003 Parameter CNT_W, default 4, width of the block-count inputs.
REQ-004 Port list (name, direction, width, meaning) SHALL be:
- clock_i, in, 1: single clock, rising-edge.
- reset_i, in, 1: synchronous, active-high reset.
- start_i, in, 1: start one encryption; honoured only in IDLE.
- ad_blocks_i, in, CNT_W: number of associated-data blocks, 0..2^CNT_W-1; sampled on the accepted start.
- pt_blocks_i, in, CNT_W: number of plaintext blocks, including the padded last block; sampled on the accepted start.
- data_valid_i, in, 1: a data block is present on the datapath input.
- data_ready_o, out, 1: the scheduler accepts a block this cycle.
- round_o, out, 4: round-constant index applied to the permutation this cycle.
- perm_en_o, out, 1: the permutation state register updates with one round this cycle.
- init_o, out, 1: load IV||K||N into the state.
- xor_data_o, out, 1: XOR the input block into the rate.
- xor_key_begin_o, out, 1: XOR the key before the finalization rounds.
- xor_key_end_o, out, 1: XOR the key after the last round of initialization or finalization.
- xor_domain_o, out, 1: XOR the domain separation bit.
- cipher_valid_o, out, 1: the ciphertext block is valid.
- tag_valid_o, out, 1: the tag is valid.
- done_o, out, 1: one-cycle end-of-operation pulse.
- busy_o, out, 1: asserted in every state except IDLE.

Function
REQ-005 The FSM states SHALL be IDLE, INIT, AD_WAIT, AD_PERM, DOMAIN, PT_WAIT, PT_PERM, FINAL and TAG.
REQ-006 IDLE with start_i=1 SHALL latch both block counts and enter INIT on the next cycle; start_i SHALL be ignored in every other state.
REQ-007 INIT SHALL last PA_ROUNDS cycles:
- perm_en_o=1 throughout.
- round_o SHALL count 0..PA_ROUNDS-1.
- init_o=1 on the first cycle only.
- xor_key_end_o=1 on the last cycle only.
REQ-008 After INIT the FSM SHALL enter AD_WAIT if the latched AD count is greater than 0, otherwise DOMAIN.
REQ-009 AD_WAIT SHALL assert data_ready_o. When data_valid_i=1 it SHALL assert xor_data_o in the same cycle, decrement the AD count and enter AD_PERM.
REQ-010 AD_PERM SHALL last PB_ROUNDS cycles:
- perm_en_o=1 throughout.
- round_o SHALL count PA_ROUNDS-PB_ROUNDS..PA_ROUNDS-1.
- On exit, the FSM SHALL enter AD_WAIT if AD blocks remain, otherwise DOMAIN.
REQ-011 DOMAIN SHALL last one cycle with xor_domain_o=1 and SHALL then enter PT_WAIT.
REQ-012 PT_WAIT SHALL assert data_ready_o. When data_valid_i=1 it SHALL assert xor_data_o and cipher_valid_o in the same cycle, then:
- enter FINAL if this was the last PT block;
- otherwise enter PT_PERM.
REQ-013 PT_PERM SHALL behave as AD_PERM and SHALL return to PT_WAIT.
REQ-014 A latched pt_blocks_i of 0 SHALL be treated as 1.
REQ-015 FINAL SHALL last PA_ROUNDS cycles:
- round_o SHALL count 0..PA_ROUNDS-1 with perm_en_o=1.
- xor_key_begin_o=1 on the first cycle.
- xor_key_end_o=1 on the last cycle.
REQ-016 TAG SHALL last one cycle with tag_valid_o=1 and done_o=1, then enter IDLE.
REQ-017 data_valid_i SHALL be ignored outside AD_WAIT and PT_WAIT.
REQ-018 The WAIT states SHALL hold indefinitely, with no permutation activity, while data_valid_i=0.
REQ-019 All outputs SHALL be registered or decoded from state and counters only. No output SHALL depend combinationally on start_i. data_ready_o, xor_data_o and cipher_valid_o are exempt and MAY depend on data_valid_i in the WAIT states.
REQ-020 Outside the cycles named above, every pulse output and round_o SHALL be 0.

Reset
REQ-021 reset_i=1 at a clock edge SHALL force IDLE and clear the round counter and the latched block counts, regardless of state or of start_i.
REQ-022 In the cycle following reset, all outputs SHALL be 0.
REQ-023 A reset during INIT, PERM or FINAL SHALL abort the operation without emitting done_o.

Verification
REQ-024 Zero AD, one PT block, data_valid_i held at 1, start_i accepted at cycle T. Required response:
- INIT on cycles T+1..T+12 with round_o 0..11.
- xor_domain_o on T+13.
- cipher_valid_o on T+14.
- FINAL on T+15..T+26.
- tag_valid_o and done_o on T+27.
REQ-025 One AD block, one PT block, valid held at 1. Required response:
- xor_data_o on T+13.
- AD_PERM on T+14..T+19 with round_o 6..11.
- xor_domain_o on T+20.
- cipher_valid_o on T+21.
- done_o on T+34.
REQ-026 Three PT blocks, with data_valid_i held low 5 cycles in the second PT_WAIT. Required response:
- perm_en_o stays 0 during the stall.
- exactly 3 cipher_valid_o pulses occur.
- 2 PT_PERM runs occur.
REQ-027 reset_i=1 on the 7th INIT cycle. Required response:
- busy_o=0 on the next cycle.
- no done_o.
- a new start_i is accepted normally.
REQ-028 start_i pulsed during FINAL, and data_valid_i=1 during INIT. Both SHALL be ignored; cycle counts and pulse counts SHALL match REQ-024.
REQ-029 ad_blocks_i=15 and pt_blocks_i=0. Required response:
- exactly 15 AD_PERM runs.
- exactly 1 cipher_valid_o pulse.
- done_o asserted.

Source files
------------

// File: rtl/ascon_round_sched.sv
// Round/phase scheduler for an Ascon-128 encryption datapath: sequences
// initialization, associated data, plaintext and finalization permutations.
module ascon_round_sched #(
    parameter int PA_ROUNDS = 12,
    parameter int PB_ROUNDS = 6,
    parameter int CNT_W     = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] ad_blocks_i,
    input  logic [CNT_W-1:0] pt_blocks_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [3:0]       round_o,
    output logic             perm_en_o,
    output logic             init_o,
    output logic             xor_data_o,
    output logic             xor_key_begin_o,
    output logic             xor_key_end_o,
    output logic             xor_domain_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD_PERM,
        S_DOMAIN,
        S_PT_WAIT,
        S_PT_PERM,
        S_FINAL,
        S_TAG
    } state_t;

    // p^b uses the last PB_ROUNDS round constants of p^a
    localparam logic [3:0]       RND_FIRST_B = 4'(PA_ROUNDS - PB_ROUNDS);
    localparam logic [3:0]       RND_LAST    = 4'(PA_ROUNDS - 1);
    localparam logic [CNT_W-1:0] ONE_BLK     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
    logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
    logic             last_round;
    logic             perm_active;
    logic             wait_state;

    assign last_round = (round_q == RND_LAST);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            round_q  <= '0;
            ad_cnt_q <= '0;
            pt_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            ad_cnt_q <= ad_cnt_d;
            pt_cnt_q <= pt_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        ad_cnt_d = ad_cnt_q;
        pt_cnt_d = pt_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_INIT;
                    round_d  = '0;
                    ad_cnt_d = ad_blocks_i;
                    pt_cnt_d = (pt_blocks_i == '0) ? ONE_BLK : pt_blocks_i;
                end
            end
            S_INIT: begin
                round_d = round_q + 4'd1;
                if (last_round) begin
                    round_d = '0;
                    state_d = (ad_cnt_q != '0) ? S_AD_WAIT : S_DOMAIN;
                end
            end
            S_AD_WAIT: begin
                if (data_valid_i) begin
                    ad_cnt_d = ad_cnt_q - ONE_BLK;
                    round_d  = RND_FIRST_B;
                    state_d  = S_AD_PERM;
                end
            end
            S_AD_PERM: begin
                round_d = round_q + 4'd1;
                if (last_round) begin
                    round_d = '0;
                    state_d = (ad_cnt_q != '0) ? S_AD_WAIT : S_DOMAIN;
                end
            end
            S_DOMAIN: begin
                state_d = S_PT_WAIT;
            end
            S_PT_WAIT: begin
                if (data_valid_i) begin
                    pt_cnt_d = pt_cnt_q - ONE_BLK;
                    if (pt_cnt_q == ONE_BLK) begin
                        round_d = '0;
                        state_d = S_FINAL;
                    end else begin
                        round_d = RND_FIRST_B;
                        state_d = S_PT_PERM;
                    end
                end
            end
            S_PT_PERM: begin
                round_d = round_q + 4'd1;
                if (last_round) begin
                    round_d = '0;
                    state_d = S_PT_WAIT;
                end
            end
            S_FINAL: begin
                round_d = round_q + 4'd1;
                if (last_round) begin
                    round_d = '0;
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
            end
        endcase
    end

    // Outputs decode state/counters only; data_valid_i feeds just the WAIT handshakes
    always_comb begin
        perm_active = (state_q == S_INIT) || (state_q == S_AD_PERM) ||
                      (state_q == S_PT_PERM) || (state_q == S_FINAL);
        wait_state  = (state_q == S_AD_WAIT) || (state_q == S_PT_WAIT);

        perm_en_o       = perm_active;
        round_o         = perm_active ? round_q : '0;
        init_o          = (state_q == S_INIT) && (round_q == '0);
        xor_key_begin_o = (state_q == S_FINAL) && (round_q == '0);
        xor_key_end_o   = ((state_q == S_INIT) || (state_q == S_FINAL)) && last_round;
        xor_domain_o    = (state_q == S_DOMAIN);
        data_ready_o    = wait_state;
        xor_data_o      = wait_state && data_valid_i;
        cipher_valid_o  = (state_q == S_PT_WAIT) && data_valid_i;
        tag_valid_o     = (state_q == S_TAG);
        done_o          = (state_q == S_TAG);
        busy_o          = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_ascon_round_sched.sv
// Directed bench for ascon_round_sched: table of whole-message transactions
// plus cycle-exact, reset-abort and ignored-input sequences.
module tb_ascon_round_sched;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [3:0] ad_blocks_i;
    logic [3:0] pt_blocks_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       perm_en_o;
    logic       init_o;
    logic       xor_data_o;
    logic       xor_key_begin_o;
    logic       xor_key_end_o;
    logic       xor_domain_o;
    logic       cipher_valid_o;
    logic       tag_valid_o;
    logic       done_o;
    logic       busy_o;

    logic [14:0] obus;
    assign obus = {data_ready_o, round_o, perm_en_o, init_o, xor_data_o, xor_key_begin_o,
                   xor_key_end_o, xor_domain_o, cipher_valid_o, tag_valid_o, done_o, busy_o};

    ascon_round_sched #(.PA_ROUNDS(12), .PB_ROUNDS(6), .CNT_W(4)) dut (
        .clock_i(clk), .reset_i(reset_i), .start_i(start_i),
        .ad_blocks_i(ad_blocks_i), .pt_blocks_i(pt_blocks_i), .data_valid_i(data_valid_i),
        .data_ready_o(data_ready_o), .round_o(round_o), .perm_en_o(perm_en_o),
        .init_o(init_o), .xor_data_o(xor_data_o), .xor_key_begin_o(xor_key_begin_o),
        .xor_key_end_o(xor_key_end_o), .xor_domain_o(xor_domain_o),
        .cipher_valid_o(cipher_valid_o), .tag_valid_o(tag_valid_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ad; int pt; int stall;
        int cyc; int cv; int adp; int ptp; int perm; int xd;
    } vec_t;

    typedef struct {
        int cyc; int cv; int adp; int ptp; int perm; int xd;
        int dom; int ini; int kb; int ke; int tag; int stall_perm; int bad;
    } meas_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] pack(input logic rdy, input logic [3:0] rnd,
        input logic pe, input logic ini, input logic xd, input logic kb, input logic ke,
        input logic dom, input logic cv, input logic tg, input logic dn, input logic bsy);
        return {rdy, rnd, pe, ini, xd, kb, ke, dom, cv, tg, dn, bsy};
    endfunction

    // Expected outputs for the zero-AD / one-PT message, valid held high
    function automatic logic [14:0] exp024(input int c);
        if (c >= 1 && c <= 12)
            return pack(1'b0, 4'(c - 1), 1'b1, c == 1, 1'b0, 1'b0, c == 12,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (c == 13) return pack(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        if (c == 14) return pack(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        if (c >= 15 && c <= 26)
            return pack(1'b0, 4'(c - 15), 1'b1, 1'b0, 1'b0, c == 15, c == 26,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        if (c == 27) return pack(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        return '0;
    endfunction

    // Runs one message from an IDLE DUT; stalls the second PT block if asked
    task automatic run_txn(input int ad, input int pt, input int stall_len, output meas_t m);
        logic prev_pe;
        bit   dom_seen;
        int   stall_left;
        m = '{default: 0};
        prev_pe = 1'b0;
        dom_seen = 1'b0;
        stall_left = stall_len;
        @(posedge clk); #1;
        ad_blocks_i = 4'(ad);
        pt_blocks_i = 4'(pt);
        start_i = 1'b1;
        data_valid_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (m.cyc < 400) begin
            m.cyc++;
            if (stall_left > 0 && data_ready_o && dom_seen && m.cv == 1) begin
                data_valid_i = 1'b0;
                stall_left--;
            end else begin
                data_valid_i = 1'b1;
            end
            #1;
            if (!data_valid_i && perm_en_o) m.stall_perm++;
            if (perm_en_o) m.perm++;
            if (cipher_valid_o) m.cv++;
            if (xor_data_o) m.xd++;
            if (init_o) m.ini++;
            if (xor_key_begin_o) m.kb++;
            if (xor_key_end_o) m.ke++;
            if (tag_valid_o) m.tag++;
            if (perm_en_o && round_o == 4'd6 && !prev_pe) begin
                if (dom_seen) m.ptp++;
                else m.adp++;
            end
            prev_pe = perm_en_o;
            if (xor_domain_o) begin
                dom_seen = 1'b1;
                m.dom++;
            end
            if (!perm_en_o && round_o != 4'd0) m.bad++;
            if (!busy_o) m.bad++;
            if (done_o) break;
            @(posedge clk); #1;
        end
        data_valid_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[5];
        meas_t m;
        int    dones;

        vecs[0] = '{ad: 0,  pt: 1, stall: 0, cyc: 27,  cv: 1, adp: 0,  ptp: 0, perm: 24,  xd: 1};
        vecs[1] = '{ad: 1,  pt: 1, stall: 0, cyc: 34,  cv: 1, adp: 1,  ptp: 0, perm: 30,  xd: 2};
        vecs[2] = '{ad: 0,  pt: 3, stall: 5, cyc: 46,  cv: 3, adp: 0,  ptp: 2, perm: 36,  xd: 3};
        vecs[3] = '{ad: 15, pt: 0, stall: 0, cyc: 132, cv: 1, adp: 15, ptp: 0, perm: 114, xd: 16};
        vecs[4] = '{ad: 2,  pt: 2, stall: 0, cyc: 48,  cv: 2, adp: 2,  ptp: 1, perm: 42,  xd: 4};

        reset_i = 1'b1;
        start_i = 1'b1;
        ad_blocks_i = 4'd1;
        pt_blocks_i = 4'd1;
        data_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'(obus), 0);
        reset_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", int'(obus), 0);

        for (int i = 0; i < 5; i++) begin
            run_txn(vecs[i].ad, vecs[i].pt, vecs[i].stall, m);
            check($sformatf("v%0d_cycles", i), m.cyc, vecs[i].cyc);
            check($sformatf("v%0d_cipher", i), m.cv, vecs[i].cv);
            check($sformatf("v%0d_ad_perm", i), m.adp, vecs[i].adp);
            check($sformatf("v%0d_pt_perm", i), m.ptp, vecs[i].ptp);
            check($sformatf("v%0d_perm_cyc", i), m.perm, vecs[i].perm);
            check($sformatf("v%0d_xor_data", i), m.xd, vecs[i].xd);
            check($sformatf("v%0d_domain", i), m.dom, 1);
            check($sformatf("v%0d_init", i), m.ini, 1);
            check($sformatf("v%0d_key_begin", i), m.kb, 1);
            check($sformatf("v%0d_key_end", i), m.ke, 2);
            check($sformatf("v%0d_tag", i), m.tag, 1);
            check($sformatf("v%0d_stall_perm", i), m.stall_perm, 0);
            check($sformatf("v%0d_round_busy", i), m.bad, 0);
        end

        // Cycle-exact single-block message; start during FINAL, valid during INIT
        @(posedge clk); #1;
        ad_blocks_i = 4'd0;
        pt_blocks_i = 4'd1;
        data_valid_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        ad_blocks_i = 4'd3;
        for (int c = 1; c <= 30; c++) begin
            start_i = (c == 20);
            #1;
            check($sformatf("seq_c%0d", c), int'(obus), int'(exp024(c)));
            @(posedge clk); #1;
        end
        start_i = 1'b0;

        // Reset on the 7th INIT cycle aborts silently
        @(posedge clk); #1;
        ad_blocks_i = 4'd2;
        pt_blocks_i = 4'd2;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 7) begin
                check("abort_round6", int'(round_o), 6);
                reset_i = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        reset_i = 1'b0;
        check("abort_busy", int'(busy_o), 0);
        check("abort_outputs", int'(obus), 0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done_o || busy_o) dones++;
        end
        check("abort_no_done", dones, 0);
        run_txn(0, 1, 0, m);
        check("restart_cycles", m.cyc, 27);
        check("restart_cipher", m.cv, 1);
        check("restart_tag", m.tag, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
